copy_fifo: RTL

Single-clock synchronous FIFO between the read and write halves of the scan-IP AXI-Lite copy engine. The read channel pushes each captured RDATA beat with `wr_en`/`data_in` and throttles on `almost_full`. The write channel pops with `rd_en` one cycle before it drives WDATA from `data_out`, and polls `empty`. The FIFO also provides occupancy and sticky overflow/underflow flags for the status path.

---
 rtl/scan_ip_pkg.sv | 18 +
 rtl/copy_fifo_ram.sv | 35 +++
 rtl/copy_fifo.sv | 82 ++++++++
 3 files changed

// File: rtl/scan_ip_pkg.sv
// Shared definitions for the scan-IP AXI-Lite copy engine.
// Provides the ceil-log2 helper and default bus/FIFO sizing.
package scan_ip_pkg;

  localparam int SCAN_DATA_WIDTH = 32;
  localparam int COPY_FIFO_DEPTH = 16;

  // Ceil of log2; evaluated at elaboration to size pointers and counters.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/copy_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read into a resettable output register.
// Read latency 1 cycle; the output register holds until the next read enable.
module copy_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  input  logic                  rclr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/copy_fifo.sv
// Single-clock FIFO between the copy engine read and write channels, with occupancy and sticky error flags.
// Pop data appears on data_out one cycle after the accepting edge; pushes when full and pops when empty are dropped.
module copy_fifo
  import scan_ip_pkg::*;
#(
  parameter int DATA_WIDTH = SCAN_DATA_WIDTH,
  parameter int DEPTH      = COPY_FIFO_DEPTH,
  parameter int AF_MARGIN  = 2
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESETN,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [clogb2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = clogb2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          flush;
  logic          push_ok;
  logic          pop_ok;

  // Flags come straight from registered pointers, so no request-to-output path exists.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_LEVEL);

  assign flush   = !M_AXI_ARESETN || clear;
  assign push_ok = wr_en && !full && !flush;
  assign pop_ok  = rd_en && !empty && !flush;

  always_ff @(posedge M_AXI_ACLK) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  copy_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (M_AXI_ACLK),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rclr  (flush),
    .rdata (data_out)
  );

endmodule
